// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer.
// Stall vectors, FSM states, and reset/flush encodings.
package pipe_ctrl_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        FLUSH_ENABLE  = 1'b1;
    localparam logic        FLUSH_DISABLE = 1'b0;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] ERR_VEC_DEFAULT = 32'h0000_0380;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_ctrl_bus_wait_timer.sv
// Wait-cycle counter for MEM-stage bus accesses.
// Clear wins over enable; saturates instead of wrapping.
module bus_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [CNT_W-1:0] count;

    // Count wait cycles, holding at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, MEM bus wait/timeout,
// and one-cycle flush with redirect PC.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          TIMEOUT = 255,
    parameter int          CNT_W   = 8,
    parameter logic [31:0] ERR_VEC = ERR_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mem_req,
    input  logic        dbus_ack,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        dbus_err
);

    state_t     state;
    logic       wait_miss;
    logic       timer_clear;
    logic       timer_en;
    logic       timer_done;
    logic [5:0] ex_id_stall;

    assign wait_miss = mem_req & ~dbus_ack;

    // Counter restarts on entry to MEM_WAIT and advances each unacked wait
    assign timer_clear = (state == ST_RUN) & ~excp_req & wait_miss;
    assign timer_en    = (state == ST_MEM_WAIT) & ~excp_req & wait_miss;

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .done   (timer_done)
    );

    // EX hazard outranks ID hazard when no MEM stall is active
    always_comb begin
        ex_id_stall = STALL_NONE;
        if (stallreq_ex) begin
            ex_id_stall = STALL_EX;
        end else if (stallreq_id) begin
            ex_id_stall = STALL_ID;
        end
    end

    // Combinational hold vector; exceptions and flush release everything
    always_comb begin
        stall = STALL_NONE;
        if (rst != RST_ENABLE) begin
            unique case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (excp_req) begin
                        stall = STALL_NONE;
                    end else if (wait_miss) begin
                        stall = STALL_MEM;
                    end else begin
                        stall = ex_id_stall;
                    end
                end
                ST_FLUSH: stall = STALL_NONE;
                default:  stall = STALL_NONE;
            endcase
        end
    end

    // Sequencer FSM with registered flush, redirect PC and bus error pulse
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_RUN;
            flush    <= FLUSH_DISABLE;
            new_pc   <= ZERO_WORD;
            dbus_err <= 1'b0;
        end else begin
            flush    <= FLUSH_DISABLE;
            dbus_err <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (excp_req) begin
                        state  <= ST_FLUSH;
                        flush  <= FLUSH_ENABLE;
                        new_pc <= excp_pc;
                    end else if (wait_miss) begin
                        state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (excp_req) begin
                        state  <= ST_FLUSH;
                        flush  <= FLUSH_ENABLE;
                        new_pc <= excp_pc;
                    end else if (!wait_miss) begin
                        state <= ST_RUN;
                    end else if (timer_done) begin
                        state    <= ST_FLUSH;
                        flush    <= FLUSH_ENABLE;
                        dbus_err <= 1'b1;
                        new_pc   <= ERR_VEC;
                    end
                end
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates the per-stage stall vector consumed by the PC and all inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences MEM-stage data-bus accesses with a wait/timeout counter and issues a one-cycle flush plus redirect PC on exceptions or bus timeouts.

Parameters:
TIMEOUT, 255, number of MEM_WAIT cycles without dbus_ack before a bus error is declared (must be >=1)
CNT_W, 8, width of wait counter; must hold TIMEOUT
ERR_VEC, 32'h0000_0380, redirect PC used on bus timeout

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous reset, active-high (RstEnable = 1'b1)
stallreq_id  in  1  load-use hazard from ID
stallreq_ex  in  1  multi-cycle EX op (mul/div) not finished
mem_req  in  1  MEM stage holds a valid load/store this cycle
dbus_ack  in  1  data bus completes the access this cycle
excp_req  in  1  exception detected in MEM stage
excp_pc  in  32  handler address accompanying excp_req
stall  out  6  hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; combinational
flush  out  1  registered; clear all inter-stage registers to NOP
new_pc  out  32  registered; redirect target, valid while flush=1
dbus_err  out  1  registered one-cycle pulse on bus timeout

Behaviour:
- Reset (rst=1 at edge): state RUN, counter 0, flush 0, new_pc 32'h0, dbus_err 0. While rst=1, stall = 6'b000000.
- States: RUN, MEM_WAIT, FLUSH (encodings in package).
- Stall encodings: NONE 6'b000000, ID 6'b000111, EX 6'b001111, MEM 6'b011111. A held stage feeding a non-held stage inserts a bubble downstream.
- RUN, priority high to low:
  - excp_req: stall NONE; next FLUSH; new_pc <= excp_pc. Any concurrent mem access is dropped.
  - mem_req & !dbus_ack: stall MEM; next MEM_WAIT; counter <= 0.
  - mem_req & dbus_ack: no MEM stall; evaluate ex/id below in the same cycle.
  - stallreq_ex: stall EX.
  - stallreq_id: stall ID.
  - Otherwise stall NONE.
- MEM_WAIT:
  - excp_req: stall NONE; next FLUSH; new_pc <= excp_pc.
  - dbus_ack: MEM stall released this cycle; ex/id priority applies; next RUN.
  - mem_req=0 (abandoned access): stall per ex/id; next RUN.
  - Otherwise stall MEM; counter += 1.
  - When counter = TIMEOUT-1 and no ack: dbus_err <= 1 for one cycle; new_pc <= ERR_VEC; next FLUSH.
- FLUSH: flush=1 for exactly one cycle; stall NONE; all requests ignored; next RUN; flush and dbus_err return to 0.
- Latency: excp_req at cycle N gives flush=1 and new_pc valid in cycle N+1 only. Timeout gives dbus_err and flush together in the cycle after the final wait cycle.
- The counter saturates and never wraps; it resets on entry to MEM_WAIT.
- rst mid-MEM_WAIT or mid-FLUSH: everything returns to reset values at that edge; a pending flush is not issued.
- Back-to-back: excp_req asserted during FLUSH is ignored; MEM re-raises it after the refill if still valid.

Decomposition:
- Defines.v: stall vector constants (STALL_NONE/ID/EX/MEM), state encodings, ERR_VEC default, FlushEnable/FlushDisable, reuse of RstEnable/ZeroWord.
- One sub-module, bus_wait_timer: counter with clear, enable and terminal-count output, parameterised by TIMEOUT/CNT_W.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests high -> stall=0, flush=0, new_pc=0, dbus_err=0.
- Priority: stallreq_id=1 and stallreq_ex=1 in RUN -> stall=6'b001111; drop ex -> stall=6'b000111 the same cycle.
- Bus wait: mem_req=1, dbus_ack=0 for 3 cycles, then ack -> stall=6'b011111 for 3 cycles, 6'b000000 in the ack cycle, state RUN next.
- Timeout with TIMEOUT=4: mem_req held, never acked -> dbus_err=1 and flush=1 in one cycle, new_pc=32'h380, stall released; counter cleared on next access.
- Exception during MEM_WAIT: excp_req=1, excp_pc=32'hBFC0_0380 on wait cycle 2 -> next cycle flush=1, new_pc=32'hBFC0_0380, stall=0; one cycle later flush=0.
- Reset during FLUSH-pending: excp_req at cycle N, rst=1 at edge N+1 -> flush stays 0 and state is RUN.
